max_seq_driver: RTL and testbench

Stream source for the find-max FSM-D consumer. It buffers a host-loaded sequence of bytes, then replays it to the consumer: a one-cycle start pulse, then one byte per cycle. It waits for the consumer's done pulse, captures the reported maximum and returns it to the host. It sits between the host/testbench loader and the max-finder datapath.

---
 rtl/max_seq_pkg.sv | 20 ++
 rtl/seq_buffer.sv | 45 ++++
 rtl/max_seq_driver.sv | 131 +++++++++++++
 tb/tb_max_seq_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_seq_pkg.sv
// Shared types and defaults for the find-max stream driver.
// Imported by the buffer and the top-level sequencer.
package max_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        WAIT_DONE
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 255;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/seq_buffer.sv
// Append-only sequence store with combinational read by index.
// The write pointer is the low bits of count; clear only resets count.
module seq_buffer
    import max_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CW     = cnt_w(DEPTH),
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [CW-1:0]     count,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              push;

    assign full    = (count == CW'(DEPTH));
    assign push    = wr_en && !full;
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/max_seq_driver.sv
// Replays a host-loaded byte sequence to the find-max consumer
// and captures the maximum it reports back.
module max_seq_driver
    import max_seq_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    input  logic                      send,
    output logic                      busy,
    output logic                      start,
    output logic [DATA_W-1:0]         data_out,
    output logic                      last,
    input  logic                      done_in,
    input  logic [DATA_W-1:0]         max_in,
    output logic [DATA_W-1:0]         result,
    output logic                      result_valid,
    output logic                      err
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    logic [CW-1:0]     len;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     nxt;
    logic [CW-1:0]     len_now;
    logic [TW-1:0]     tmo;
    logic [DATA_W-1:0] rd_data;
    logic [AW-1:0]     rd_idx;
    logic              idle;
    logic              wr_acc;
    logic              clr;

    assign idle    = (state == IDLE);
    assign busy    = !idle;
    assign wr_acc  = wr_en && idle && !full;
    assign len_now = count + CW'(wr_acc);
    assign nxt     = idx + 1'b1;
    assign rd_idx  = idle ? '0 : nxt[AW-1:0];
    assign clr     = (state == WAIT_DONE) && (done_in || tmo == TMO_LAST);

    seq_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && idle),
        .wr_data (wr_data),
        .clr     (clr),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .count   (count),
        .full    (full)
    );

    // Stream outputs are loaded on the edge that enters each state,
    // so start/last/data_out line up with START and STREAM exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            len          <= '0;
            idx          <= '0;
            tmo          <= '0;
            start        <= 1'b0;
            data_out     <= '0;
            last         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            start        <= 1'b0;
            last         <= 1'b0;
            data_out     <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send) begin
                        if (len_now == '0) begin
                            err <= 1'b1;
                        end else begin
                            state    <= START;
                            len      <= len_now;
                            idx      <= '0;
                            start    <= 1'b1;
                            last     <= (len_now == CW'(1));
                            // empty buffer: the first byte is still in flight
                            data_out <= (count == '0) ? wr_data : rd_data;
                        end
                    end
                end
                START, STREAM: begin
                    if (idx == len - 1'b1) begin
                        state <= WAIT_DONE;
                        tmo   <= '0;
                    end else begin
                        state    <= STREAM;
                        idx      <= nxt;
                        data_out <= rd_data;
                        last     <= (nxt == len - 1'b1);
                    end
                end
                WAIT_DONE: begin
                    if (done_in) begin
                        result       <= max_in;
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end else if (tmo == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_seq_driver.sv
// Scoreboard bench for max_seq_driver: stream bytes are queued at send
// and popped by a monitor one per cycle.
module tb_max_seq_driver;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full;
    logic [4:0]    count;
    logic          send = 1'b0;
    logic          busy;
    logic          start;
    logic [DW-1:0] data_out;
    logic          last;
    logic          done_in = 1'b0;
    logic [DW-1:0] max_in = '0;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          err;

    typedef struct packed {
        logic          s;
        logic          l;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] last_res = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    max_seq_driver #(
        .DATA_W  (DW),
        .DEPTH   (DEP),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .count        (count),
        .send         (send),
        .busy         (busy),
        .start        (start),
        .data_out     (data_out),
        .last         (last),
        .done_in      (done_in),
        .max_in       (max_in),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mdl_max();
        logic [DW-1:0] m = '0;
        foreach (mdl[i]) if (mdl[i] > m) m = mdl[i];
        return m;
    endfunction

    // one scoreboard entry per cycle after the send edge
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("start", start, e.s);
            chk("last", last, e.l);
            chk("data_out", data_out, e.d);
        end
    end

    task automatic load(input logic [DW-1:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick;
        wr_en = 1'b0;
        if (mdl.size() < DEP) mdl.push_back(b);
    endtask

    task automatic replay(input bit noise);
        int n;
        int guard;
        n    = mdl.size();
        send = 1'b1;
        tick;
        send  = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < n; i++)
            exp_q.push_back({i == 0, i == n - 1, mdl[i]});
        exp_q.push_back('0);
        guard = 0;
        while (exp_q.size() > 0 && guard < DEP + 8) begin
            if (noise) begin
                wr_en   = 1'b1;
                wr_data = 8'hEE;
                send    = 1'b1;
            end
            tick;
            guard++;
        end
        wr_en = 1'b0;
        send  = 1'b0;
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        chk("busy_wait", busy, 1'b1);
    endtask

    task automatic finish_done;
        done_in = 1'b1;
        max_in  = mdl_max();
        tick;
        done_in  = 1'b0;
        last_res = mdl_max();
        chk("result", result, last_res);
        chk("result_valid", result_valid, 1'b1);
        chk("count_clr", count, 0);
        chk("busy_done", busy, 1'b0);
        chk("err_done", err, 1'b0);
        tick;
        chk("rv_pulse", result_valid, 1'b0);
        chk("result_hold", result, last_res);
        mdl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) begin
            wr_en   = 1'($urandom);
            wr_data = 8'($urandom);
            send    = 1'($urandom);
            done_in = 1'($urandom);
            max_in  = 8'($urandom);
            tick;
            chk("rst_count", count, 0);
            chk("rst_full", full, 0);
            chk("rst_busy", busy, 0);
            chk("rst_start", start, 0);
            chk("rst_data", data_out, 0);
            chk("rst_last", last, 0);
            chk("rst_result", result, 0);
            chk("rst_rv", result_valid, 0);
            chk("rst_err", err, 0);
        end
        wr_en   = 1'b0;
        send    = 1'b0;
        done_in = 1'b0;
        rst     = 1'b1;
        tick;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_count", count, 0);

        load(8'd3);
        load(8'd9);
        load(8'd5);
        chk("count3", count, 3);
        replay(1'b0);
        finish_done();

        load(8'h7F);
        replay(1'b0);
        finish_done();

        for (int i = 0; i < DEP + 1; i++) load(8'($urandom));
        chk("full", full, 1'b1);
        chk("count_full", count, DEP);
        replay(1'b0);
        finish_done();

        send = 1'b1;
        tick;
        send = 1'b0;
        chk("empty_err", err, 1'b1);
        chk("empty_busy", busy, 1'b0);
        tick;
        chk("empty_err_pulse", err, 1'b0);

        wr_en   = 1'b1;
        wr_data = 8'hA5;
        mdl.push_back(8'hA5);
        replay(1'b0);
        finish_done();

        load(8'h11);
        load(8'h44);
        load(8'h22);
        load(8'h33);
        replay(1'b1);
        finish_done();

        load(8'h10);
        load(8'h20);
        replay(1'b0);
        repeat (TMO - 2) tick;
        chk("tmo_early_err", err, 1'b0);
        chk("tmo_early_busy", busy, 1'b1);
        tick;
        chk("tmo_err", err, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_result", result, last_res);
        chk("tmo_rv", result_valid, 1'b0);
        chk("tmo_count", count, 0);
        tick;
        chk("tmo_err_pulse", err, 1'b0);
        mdl.delete();

        load(8'h61);
        load(8'h62);
        replay(1'b0);
        repeat (TMO - 2) tick;
        done_in = 1'b1;
        max_in  = mdl_max();
        tick;
        done_in  = 1'b0;
        last_res = mdl_max();
        chk("late_done_err", err, 1'b0);
        chk("late_done_rv", result_valid, 1'b1);
        chk("late_done_result", result, last_res);
        mdl.delete();

        for (int i = 0; i < 5; i++) load(8'(8'h30 + i));
        send = 1'b1;
        tick;
        send = 1'b0;
        chk("ms_start", start, 1'b1);
        chk("ms_d0", data_out, mdl[0]);
        tick;
        chk("ms_d1", data_out, mdl[1]);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_start", start, 0);
        chk("ar_last", last, 0);
        chk("ar_data", data_out, 0);
        chk("ar_count", count, 0);
        chk("ar_busy", busy, 0);
        #1;
        rst = 1'b1;
        mdl.delete();
        tick;
        send = 1'b1;
        tick;
        send = 1'b0;
        chk("ar_send_err", err, 1'b1);
        chk("ar_send_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
